id_ex_pipe_reg: RTL
===================

// Module: id_ex_pipe_reg
// PURPOSE
//   ID/EX pipeline register of the 5-stage core. Sits directly downstream of the
//   stall mux: captures its (possibly zeroed) control bits plus decoded operands
//   and presents them to EX one cycle later.
//   Supports hold (stall), flush (squash) and a valid tag, so EX and the forwarding
//   unit can tell real instructions from bubbles.
// PARAMETERS
//   DATA_W      32  width of register-file read data and immediate
//   REG_ADDR_W  5   width of rs1/rs2/rd addresses
//   FUNCT_W     10  width of packed {funct7,funct3} field
//   CNT_W       16  width of performance counters (ID_EX_PERF_CNT_EN only)
// PORTS
//   clk_i        in   1           clock, all state updates on rising edge
//   rst_i        in   1           reset, synchronous, active-low
//   stall_i      in   1           hold all stage contents this cycle
//   flush_i      in   1           squash: load an invalid all-zero entry
//   valid_i      in   1           ID slot holds a real instruction
//   bubble_i     in   1           stall mux zeroed the controls this cycle
//   aluOp_i      in   2           ALU op class from stall mux
//   aluSrc_i     in   1           ALU B source select from stall mux
//   memRead_i    in   1           load enable from stall mux
//   memWrite_i   in   1           store enable from stall mux
//   memToReg_i   in   1           writeback source select from stall mux
//   regWrite_i   in   1           register write enable from stall mux
//   rs1Data_i    in   DATA_W      register file read port 1
//   rs2Data_i    in   DATA_W      register file read port 2
//   imm_i        in   DATA_W      sign-extended immediate
//   funct_i      in   FUNCT_W     {funct7,funct3}
//   rs1Addr_i    in   REG_ADDR_W  source register 1 index
//   rs2Addr_i    in   REG_ADDR_W  source register 2 index
//   rdAddr_i     in   REG_ADDR_W  destination register index
//   <each of the 13 fields above from aluOp to rdAddr>_o  out  same width  registered copy
//   valid_o      out  1           EX slot holds a real, non-bubble instruction
//   bubbleCnt_o  out  CNT_W       bubbles inserted into EX (saturating)
//   flushCnt_o   out  CNT_W       flush cycles seen (saturating)
// BEHAVIOUR
//   - Latency 1 cycle: values at ID at edge N appear on _o after edge N.
//   - Priority at each rising edge: reset > flush > stall > load.
//   - Reset (rst_i==0 at edge): every output, including valid_o and counters, is 0.
//     Reset during stall or flush still clears everything.
//   - Flush: all control and data outputs are 0; valid_o is 0. Flush with
//     stall_i==1 is a flush; the held entry is discarded.
//   - Stall (no flush): all outputs keep their value, valid_o included. Any
//     number of consecutive stall cycles is allowed.
//   - Load: all _o take their _i value. valid_o = valid_i & ~bubble_i.
//   - bubble_i==1 with nonzero controls is a stall-mux fault. The register still
//     loads verbatim and does no sanitising.
//   - No combinational path from any input to any output.
// CONFIGURATION
//   ID_EX_PERF_CNT_EN defined:
//     - bubbleCnt_o increments on each load cycle with bubble_i==1.
//     - flushCnt_o increments on each flush cycle, stalled or not.
//     - Both counters saturate at all-ones; they do not wrap.
//     - Neither counter changes on stall-only cycles.
//     - Both counters clear only on reset.
//   ID_EX_PERF_CNT_EN undefined:
//     - Counter registers are not built.
//     - bubbleCnt_o and flushCnt_o are tied to 0.
//     - The port list is unchanged.
// TESTING
//   - Reset: drive all inputs to 1, rst_i=0 for 1 edge -> every output, valid_o and counters read 0.
//   - Load: valid_i=1, bubble_i=0, regWrite_i=1, aluOp_i=2'b10,
//     rs1Data_i=32'h1234_5678, rdAddr_i=5'd7
//     -> next cycle the same values on _o and valid_o=1.
//   - Stall: load rdAddr=5, then stall_i=1 for 3 cycles while rdAddr_i=9
//     -> rdAddr_o stays 5 for all 3 cycles and becomes 9 one edge after stall drops.
//   - Flush over stall: stall_i=1 and flush_i=1 with a valid entry held
//     -> next cycle all outputs 0, valid_o=0; with _EN, flushCnt_o +1.
//   - Bubble: valid_i=1, bubble_i=1, controls all 0 -> valid_o=0; with _EN, bubbleCnt_o +1.
//     With CNT_W=4, 20 bubbles -> bubbleCnt_o=4'hF.
//   - Build without ID_EX_PERF_CNT_EN and rerun all tests
//     -> counters read 0 throughout; all other results are identical.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_reg
// Description : ID/EX pipeline register with hold, flush and valid tagging.
//               Optional saturating bubble/flush counters are built when
//               ID_EX_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int FUNCT_W    = 10,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic                  bubble_i,
    input  logic [1:0]            aluOp_i,
    input  logic                  aluSrc_i,
    input  logic                  memRead_i,
    input  logic                  memWrite_i,
    input  logic                  memToReg_i,
    input  logic                  regWrite_i,
    input  logic [DATA_W-1:0]     rs1Data_i,
    input  logic [DATA_W-1:0]     rs2Data_i,
    input  logic [DATA_W-1:0]     imm_i,
    input  logic [FUNCT_W-1:0]    funct_i,
    input  logic [REG_ADDR_W-1:0] rs1Addr_i,
    input  logic [REG_ADDR_W-1:0] rs2Addr_i,
    input  logic [REG_ADDR_W-1:0] rdAddr_i,
    output logic [1:0]            aluOp_o,
    output logic                  aluSrc_o,
    output logic                  memRead_o,
    output logic                  memWrite_o,
    output logic                  memToReg_o,
    output logic                  regWrite_o,
    output logic [DATA_W-1:0]     rs1Data_o,
    output logic [DATA_W-1:0]     rs2Data_o,
    output logic [DATA_W-1:0]     imm_o,
    output logic [FUNCT_W-1:0]    funct_o,
    output logic [REG_ADDR_W-1:0] rs1Addr_o,
    output logic [REG_ADDR_W-1:0] rs2Addr_o,
    output logic [REG_ADDR_W-1:0] rdAddr_o,
    output logic                  valid_o,
    output logic [CNT_W-1:0]      bubbleCnt_o,
    output logic [CNT_W-1:0]      flushCnt_o
);

    logic [1:0]            r_alu_op;
    logic                  r_alu_src;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_mem_to_reg;
    logic                  r_reg_write;
    logic [DATA_W-1:0]     r_rs1_data;
    logic [DATA_W-1:0]     r_rs2_data;
    logic [DATA_W-1:0]     r_imm;
    logic [FUNCT_W-1:0]    r_funct;
    logic [REG_ADDR_W-1:0] r_rs1_addr;
    logic [REG_ADDR_W-1:0] r_rs2_addr;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic                  r_valid;

    // Priority: reset > flush > stall > load. Bubble entries load verbatim.
    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            r_alu_op     <= '0;
            r_alu_src    <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_funct      <= '0;
            r_rs1_addr   <= '0;
            r_rs2_addr   <= '0;
            r_rd_addr    <= '0;
            r_valid      <= 1'b0;
        end else if (!stall_i) begin
            r_alu_op     <= aluOp_i;
            r_alu_src    <= aluSrc_i;
            r_mem_read   <= memRead_i;
            r_mem_write  <= memWrite_i;
            r_mem_to_reg <= memToReg_i;
            r_reg_write  <= regWrite_i;
            r_rs1_data   <= rs1Data_i;
            r_rs2_data   <= rs2Data_i;
            r_imm        <= imm_i;
            r_funct      <= funct_i;
            r_rs1_addr   <= rs1Addr_i;
            r_rs2_addr   <= rs2Addr_i;
            r_rd_addr    <= rdAddr_i;
            r_valid      <= valid_i & ~bubble_i;
        end
    end

    assign aluOp_o    = r_alu_op;
    assign aluSrc_o   = r_alu_src;
    assign memRead_o  = r_mem_read;
    assign memWrite_o = r_mem_write;
    assign memToReg_o = r_mem_to_reg;
    assign regWrite_o = r_reg_write;
    assign rs1Data_o  = r_rs1_data;
    assign rs2Data_o  = r_rs2_data;
    assign imm_o      = r_imm;
    assign funct_o    = r_funct;
    assign rs1Addr_o  = r_rs1_addr;
    assign rs2Addr_o  = r_rs2_addr;
    assign rdAddr_o   = r_rd_addr;
    assign valid_o    = r_valid;

`ifdef ID_EX_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating counters; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (flush_i) begin
            if (r_flush_cnt != c_CNT_MAX) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end else if (!stall_i && bubble_i) begin
            if (r_bubble_cnt != c_CNT_MAX) begin
                r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
            end
        end
    end

    assign bubbleCnt_o = r_bubble_cnt;
    assign flushCnt_o  = r_flush_cnt;
`else
    assign bubbleCnt_o = '0;
    assign flushCnt_o  = '0;
`endif

endmodule
`default_nettype wire
